// File: rtl/spi_ss_pkg.sv
// Shared types and encodings for the multi-slave SPI select/frame timer.
package spi_ss_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } ss_state_t;

    localparam logic [1:0] SPI_RUN  = 2'b00;
    localparam logic [1:0] SPI_WAIT = 2'b01;

    // Width of the slave index port; a single slave still needs one bit.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_ss_phase_cnt.sv
// Loadable down-counter that times the SETUP, XFER and HOLD phases.
module spi_ss_phase_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    output logic             o_done
);

    logic [CNT_W-1:0] r_value;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_value <= '0;
        end else if (i_load) begin
            r_value <= i_value;
        end else if (r_value != '0) begin
            r_value <= r_value - CNT_W'(1);
        end
    end

    assign o_done = (r_value == '0);

endmodule

// File: rtl/spi_multi_slave_select.sv
// SPI master slave-select and frame timer: drives NUM_SS active-low selects around
// each frame with programmable setup/hold and optional back-to-back frames.
//
// state | meaning
// IDLE  | all selects high, waiting for send_data
// SETUP | select low, cs_setup cycles before the frame
// XFER  | frame in progress, target cycles
// HOLD  | select low, cs_hold cycles after the frame
module spi_multi_slave_select
    import spi_ss_pkg::*;
#(
    parameter int NUM_SS = 4,
    parameter int CNT_W  = 16,
    parameter int DLY_W  = 8
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic                      mstr,
    input  logic                      spiswai,
    input  logic [1:0]                spi_mode,
    input  logic                      send_data,
    input  logic [sel_w(NUM_SS)-1:0]  ss_sel,
    input  logic                      cont_en,
    input  logic [CNT_W-1:0]          BaudRateDivisor,
    input  logic [DLY_W-1:0]          cs_setup,
    input  logic [DLY_W-1:0]          cs_hold,
    output logic [NUM_SS-1:0]         ss_n,
    output logic                      tip,
    output logic                      receive_data,
    output logic                      err_busy,
    output logic                      err_sel
);

    localparam int SW = sel_w(NUM_SS);

    ss_state_t         r_state, w_state_nxt;
    logic [SW-1:0]     r_sel, w_sel_nxt;
    logic [CNT_W-1:0]  r_target, w_target_nxt;
    logic [CNT_W-1:0]  r_hold, w_hold_nxt;
    logic [NUM_SS-1:0] r_ss_n, w_ss_n_nxt;
    logic              r_tip, r_rx, r_eb, r_es;
    logic              w_rx_nxt, w_eb_nxt, w_es_nxt;
    logic              w_en, w_sel_ok, w_cont;
    logic              w_cnt_load, w_cnt_done;
    logic [CNT_W-1:0]  w_cnt_val, w_brd_eff, w_setup_ext, w_hold_ext;

    assign w_en        = ((spi_mode == SPI_RUN) || (spi_mode == SPI_WAIT)) && mstr && !spiswai;
    assign w_sel_ok    = (int'(ss_sel) < NUM_SS);
    assign w_brd_eff   = (BaudRateDivisor == '0) ? CNT_W'(1) : BaudRateDivisor;
    assign w_setup_ext = CNT_W'(cs_setup);
    assign w_hold_ext  = CNT_W'(cs_hold);
    assign w_cont      = send_data && cont_en && (ss_sel == r_sel);

    spi_ss_phase_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .i_load  (w_cnt_load),
        .i_value (w_cnt_val),
        .o_done  (w_cnt_done)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_sel_nxt    = r_sel;
        w_target_nxt = r_target;
        w_hold_nxt   = r_hold;
        w_cnt_load   = 1'b0;
        w_cnt_val    = '0;
        w_rx_nxt     = 1'b0;
        w_eb_nxt     = 1'b0;
        w_es_nxt     = 1'b0;

        if (!w_en) begin
            // Abort: drop the select immediately, no completion pulse.
            w_state_nxt = IDLE;
            w_cnt_load  = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (send_data && w_sel_ok) begin
                        w_sel_nxt    = ss_sel;
                        w_target_nxt = w_brd_eff;
                        w_hold_nxt   = w_hold_ext;
                        w_cnt_load   = 1'b1;
                        if (cs_setup != '0) begin
                            w_state_nxt = SETUP;
                            w_cnt_val   = w_setup_ext - CNT_W'(1);
                        end else begin
                            w_state_nxt = XFER;
                            w_cnt_val   = w_brd_eff - CNT_W'(1);
                        end
                    end else if (send_data) begin
                        w_es_nxt = 1'b1;
                    end
                end
                SETUP: begin
                    w_eb_nxt = send_data;
                    if (w_cnt_done) begin
                        w_state_nxt = XFER;
                        w_cnt_load  = 1'b1;
                        w_cnt_val   = r_target - CNT_W'(1);
                    end
                end
                XFER: begin
                    if (!w_cnt_done) begin
                        w_eb_nxt = send_data;
                    end else begin
                        w_rx_nxt = 1'b1;
                        if (w_cont) begin
                            w_target_nxt = w_brd_eff;
                            w_cnt_load   = 1'b1;
                            w_cnt_val    = w_brd_eff - CNT_W'(1);
                        end else begin
                            w_eb_nxt = send_data;
                            if (r_hold != '0) begin
                                w_state_nxt = HOLD;
                                w_cnt_load  = 1'b1;
                                w_cnt_val   = r_hold - CNT_W'(1);
                            end else begin
                                w_state_nxt = IDLE;
                            end
                        end
                    end
                end
                HOLD: begin
                    w_eb_nxt = send_data;
                    if (w_cnt_done) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end

        w_ss_n_nxt = '1;
        if (w_state_nxt != IDLE) begin
            for (int i = 0; i < NUM_SS; i++) begin
                if (int'(w_sel_nxt) == i) w_ss_n_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state  <= IDLE;
            r_sel    <= '0;
            r_target <= '0;
            r_hold   <= '0;
            r_ss_n   <= '1;
            r_tip    <= 1'b0;
            r_rx     <= 1'b0;
            r_eb     <= 1'b0;
            r_es     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sel    <= w_sel_nxt;
            r_target <= w_target_nxt;
            r_hold   <= w_hold_nxt;
            r_ss_n   <= w_ss_n_nxt;
            r_tip    <= (w_state_nxt != IDLE);
            r_rx     <= w_rx_nxt;
            r_eb     <= w_eb_nxt;
            r_es     <= w_es_nxt;
        end
    end

    assign ss_n         = r_ss_n;
    assign tip          = r_tip;
    assign receive_data = r_rx;
    assign err_busy     = r_eb;
    assign err_sel      = r_es;

endmodule

// File: tb/tb_spi_multi_slave_select.sv
// Directed scoreboard bench: expected per-cycle outputs are queued with the stimulus
// and checked #1 after each rising edge for a 4-slave and a 5-slave instance.
module tb_spi_multi_slave_select;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        mstr = 1'b1;
    logic        spiswai = 1'b0;
    logic [1:0]  spi_mode = 2'b00;
    logic        send_data = 1'b0;
    logic [2:0]  sel = 3'd0;
    logic        cont_en = 1'b0;
    logic [15:0] brd = 16'd0;
    logic [7:0]  setup = 8'd0;
    logic [7:0]  hold = 8'd0;

    logic [3:0] ss_n4;
    logic       tip4, rx4, eb4, es4;
    logic [4:0] ss_n5;
    logic       tip5, rx5, eb5, es5;

    spi_multi_slave_select #(.NUM_SS(4), .CNT_W(16), .DLY_W(8)) dut4 (
        .PCLK(PCLK), .PRESET(PRESET), .mstr(mstr), .spiswai(spiswai), .spi_mode(spi_mode),
        .send_data(send_data), .ss_sel(sel[1:0]), .cont_en(cont_en), .BaudRateDivisor(brd),
        .cs_setup(setup), .cs_hold(hold), .ss_n(ss_n4), .tip(tip4), .receive_data(rx4),
        .err_busy(eb4), .err_sel(es4)
    );

    spi_multi_slave_select #(.NUM_SS(5), .CNT_W(16), .DLY_W(8)) dut5 (
        .PCLK(PCLK), .PRESET(PRESET), .mstr(mstr), .spiswai(spiswai), .spi_mode(spi_mode),
        .send_data(send_data), .ss_sel(sel), .cont_en(cont_en), .BaudRateDivisor(brd),
        .cs_setup(setup), .cs_hold(hold), .ss_n(ss_n5), .tip(tip5), .receive_data(rx5),
        .err_busy(eb5), .err_sel(es5)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        string      tag;
        int         cyc;
        bit         d5;
        logic [8:0] exp;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    // Queue expectations {ss_n, tip, rx, err_busy, err_sel} for cycles c0..c1, kept sorted by cycle.
    task automatic expect_rng(input string tag, input int c0, input int c1, input bit d5,
                              input logic [4:0] ss, input logic t, input logic r,
                              input logic eb, input logic es);
        for (int c = c0; c <= c1; c++) begin
            exp_t e;
            int   idx;
            e.tag = tag;
            e.cyc = c;
            e.d5  = d5;
            e.exp = {ss, t, r, eb, es};
            idx   = q.size();
            while (idx > 0 && q[idx-1].cyc > c) idx--;
            q.insert(idx, e);
        end
    endtask

    task automatic step();
        exp_t       e;
        logic [8:0] obs;
        @(posedge PCLK);
        #1;
        cyc++;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e   = q.pop_front();
            obs = e.d5 ? {ss_n5, tip5, rx5, eb5, es5} : {1'b0, ss_n4, tip4, rx4, eb4, es4};
            n_assert++;
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s cyc=%0d observed=%b expected=%b (ss_n,tip,rx,eb,es)",
                       e.tag, e.cyc, obs, e.exp);
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && q.size() > 0; i++) step();
        n_assert++;
        assert (q.size() == 0) else begin
            n_fail++;
            $error("FAIL drain_timeout observed=%0d expected=0 pending", q.size());
            q.delete();
        end
        send_data = 1'b0;
        for (int i = 0; i < 3; i++) step();
    endtask

    task automatic start();
        cyc = 0;
    endtask

    task automatic send(input logic [2:0] s, input logic [7:0] su, input logic [15:0] b,
                        input logic [7:0] h);
        sel       = s;
        setup     = su;
        brd       = b;
        hold      = h;
        send_data = 1'b1;
    endtask

    initial begin
        // Reset, with a start request that must be ignored while reset is held.
        start();
        send(3'd1, 8'd0, 16'd1, 8'd0);
        expect_rng("reset4", 1, 2, 0, 4'b1111, 0, 0, 0, 0);
        expect_rng("reset5", 1, 2, 1, 5'b11111, 0, 0, 0, 0);
        step();
        send_data = 1'b0;
        step();
        PRESET = 1'b0;
        drain();

        // Setup/XFER/hold sequence; parameter changes after start must be ignored.
        start();
        send(3'd2, 8'd2, 16'd4, 8'd1);
        expect_rng("t1_frame", 1, 6, 0, 4'b1011, 1, 0, 0, 0);
        expect_rng("t1_rx",    7, 7, 0, 4'b1011, 1, 1, 0, 0);
        expect_rng("t1_end",   8, 8, 0, 4'b1111, 0, 0, 0, 0);
        step();
        send_data = 1'b0;
        setup = 8'd7; brd = 16'd9; hold = 8'd5;
        drain();

        // All-zero parameters: BRD=0 behaves as 1, no setup or hold.
        start();
        send(3'd0, 8'd0, 16'd0, 8'd0);
        expect_rng("t2_xfer", 1, 1, 0, 4'b1110, 1, 0, 0, 0);
        expect_rng("t2_rx",   2, 2, 0, 4'b1111, 0, 1, 0, 0);
        expect_rng("t2_idle", 3, 3, 0, 4'b1111, 0, 0, 0, 0);
        step();
        send_data = 1'b0;
        drain();

        // Continuous back-to-back frames on the same slave.
        start();
        cont_en = 1'b1;
        send(3'd1, 8'd0, 16'd3, 8'd2);
        expect_rng("t3_x1",   1, 3, 0, 4'b1101, 1, 0, 0, 0);
        expect_rng("t3_rx1",  4, 4, 0, 4'b1101, 1, 1, 0, 0);
        expect_rng("t3_x2",   5, 6, 0, 4'b1101, 1, 0, 0, 0);
        expect_rng("t3_rx2",  7, 7, 0, 4'b1101, 1, 1, 0, 0);
        expect_rng("t3_hold", 8, 8, 0, 4'b1101, 1, 0, 0, 0);
        expect_rng("t3_end",  9, 9, 0, 4'b1111, 0, 0, 0, 0);
        step();
        send_data = 1'b0;
        step();
        step();
        send(3'd1, 8'd0, 16'd3, 8'd2);
        step();
        send_data = 1'b0;
        drain();

        // Busy rejections: mid-frame, and on the last XFER cycle with a different slave.
        start();
        send(3'd1, 8'd0, 16'd4, 8'd0);
        expect_rng("t4_x",    1, 2, 0, 4'b1101, 1, 0, 0, 0);
        expect_rng("t4_eb1",  3, 3, 0, 4'b1101, 1, 0, 1, 0);
        expect_rng("t4_x4",   4, 4, 0, 4'b1101, 1, 0, 0, 0);
        expect_rng("t4_eb2",  5, 5, 0, 4'b1111, 0, 1, 1, 0);
        expect_rng("t4_idle", 6, 6, 0, 4'b1111, 0, 0, 0, 0);
        step();
        send_data = 1'b0;
        step();
        send(3'd3, 8'd0, 16'd4, 8'd0);
        step();
        send_data = 1'b0;
        step();
        send(3'd2, 8'd0, 16'd4, 8'd0);
        step();
        send_data = 1'b0;
        cont_en = 1'b0;
        drain();

        // Five-slave build: index 4 is valid, index 5 is rejected.
        start();
        send(3'd4, 8'd0, 16'd1, 8'd0);
        expect_rng("t5_sel4",   1, 1, 1, 5'b01111, 1, 0, 0, 0);
        expect_rng("t5_sel4rx", 2, 2, 1, 5'b11111, 0, 1, 0, 0);
        step();
        send_data = 1'b0;
        drain();
        start();
        send(3'd5, 8'd0, 16'd1, 8'd0);
        expect_rng("t5_errsel", 1, 1, 1, 5'b11111, 0, 0, 0, 1);
        expect_rng("t5_after",  2, 2, 1, 5'b11111, 0, 0, 0, 0);
        step();
        send_data = 1'b0;
        drain();

        // Stop-in-wait abort, then a request while disabled raises no flag.
        start();
        send(3'd0, 8'd0, 16'd8, 8'd0);
        expect_rng("t6_x",     1, 3, 0, 4'b1110, 1, 0, 0, 0);
        expect_rng("t6_abort", 4, 6, 0, 4'b1111, 0, 0, 0, 0);
        step();
        send_data = 1'b0;
        step();
        step();
        spiswai = 1'b1;
        step();
        send(3'd0, 8'd0, 16'd8, 8'd0);
        step();
        send_data = 1'b0;
        drain();
        spiswai = 1'b0;

        // Synchronous reset mid-frame.
        start();
        send(3'd0, 8'd0, 16'd8, 8'd0);
        expect_rng("t7_x",   1, 3, 0, 4'b1110, 1, 0, 0, 0);
        expect_rng("t7_rst", 4, 5, 0, 4'b1111, 0, 0, 0, 0);
        step();
        send_data = 1'b0;
        step();
        step();
        PRESET = 1'b1;
        step();
        PRESET = 1'b0;
        drain();

        // Wait mode: request on last HOLD cycle is busy, next IDLE cycle is accepted.
        start();
        spi_mode = 2'b01;
        send(3'd3, 8'd1, 16'd1, 8'd1);
        expect_rng("t8_sx",  1, 2, 0, 4'b0111, 1, 0, 0, 0);
        expect_rng("t8_rx",  3, 3, 0, 4'b0111, 1, 1, 0, 0);
        expect_rng("t8_eb",  4, 4, 0, 4'b1111, 0, 0, 1, 0);
        expect_rng("t8_new", 5, 5, 0, 4'b1110, 1, 0, 0, 0);
        expect_rng("t8_rx2", 6, 6, 0, 4'b1111, 0, 1, 0, 0);
        step();
        send_data = 1'b0;
        step();
        step();
        send(3'd0, 8'd0, 16'd1, 8'd0);
        step();
        send(3'd0, 8'd0, 16'd1, 8'd0);
        step();
        send_data = 1'b0;
        drain();
        spi_mode = 2'b00;

        // Inactive mode and slave mode ignore requests without flags.
        start();
        spi_mode = 2'b10;
        send(3'd0, 8'd0, 16'd1, 8'd0);
        expect_rng("t9_dis", 1, 3, 0, 4'b1111, 0, 0, 0, 0);
        step();
        spi_mode = 2'b00;
        mstr = 1'b0;
        step();
        mstr = 1'b1;
        send_data = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
